// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmitter: round-robin grant of one byte per frame,
// 8N1 framing at CLK_DIV clock cycles per bit.
module uart_tx_arbiter #(
  parameter int unsigned CLK_DIV = 417
) (
  input  logic       CLK48MHZ,
  input  logic       RST_N,
  input  logic       EN,
  input  logic       REQ0_VALID,
  input  logic [7:0] REQ0_DATA,
  output logic       REQ0_READY,
  input  logic       REQ1_VALID,
  input  logic [7:0] REQ1_DATA,
  output logic       REQ1_READY,
  output logic       TXD,
  output logic       BUSY,
  output logic       GNT_ID
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  localparam logic [15:0] BaudMax = 16'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        gnt_q, gnt_d;

  logic winner;
  logic xfer;
  logic bit_done;

  assign bit_done = (baud_q == BaudMax);

  // Both valid: hand the frame to whoever did not own the last one.
  always_comb begin
    winner = REQ1_VALID;
    if (REQ0_VALID && REQ1_VALID) begin
      winner = ~gnt_q;
    end
  end

  assign xfer = REQ0_READY | REQ1_READY;

  // State register
  always_ff @(posedge CLK48MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (xfer) state_d = StStart;
      StStart: if (bit_done) state_d = StData;
      StData:  if (bit_done && (bit_q == 3'd7)) state_d = StStop;
      StStop:  if (bit_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs; READY is suppressed while reset is held.
  always_comb begin
    REQ0_READY = 1'b0;
    REQ1_READY = 1'b0;
    if (RST_N && EN && (state_q == StIdle)) begin
      REQ0_READY = REQ0_VALID && !winner;
      REQ1_READY = REQ1_VALID && winner;
    end
  end

  assign BUSY   = (state_q != StIdle);
  assign TXD    = txd_q;
  assign GNT_ID = gnt_q;

  // Datapath next-state: the line level for the next cycle is decided here so TXD is a flop.
  always_comb begin
    baud_d  = baud_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    gnt_d   = gnt_q;
    if ((state_q == StIdle) || bit_done) begin
      baud_d = 16'd0;
    end
    unique case (state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (xfer) begin
          shift_d = winner ? REQ1_DATA : REQ0_DATA;
          gnt_d   = winner;
          bit_d   = 3'd0;
          txd_d   = 1'b0;
        end
      end
      StStart: begin
        if (bit_done) txd_d = shift_q[0];
      end
      StData: begin
        if (bit_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          txd_d   = (bit_q == 3'd7) ? 1'b1 : shift_q[1];
        end
      end
      StStop: begin
        txd_d = 1'b1;
      end
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK48MHZ or negedge RST_N) begin
    if (!RST_N) begin
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      txd_q   <= 1'b1;
      gnt_q   <= 1'b1;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      gnt_q   <= gnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter: a queue-of-line-levels model is checked every
// cycle, plus literal checks for the directed scenarios.
module tb_uart_tx_arbiter;

  localparam int unsigned Div = 4;

  logic       CLK48MHZ = 1'b0;
  logic       RST_N = 1'b0;
  logic       EN = 1'b0;
  logic       REQ0_VALID = 1'b0;
  logic [7:0] REQ0_DATA = 8'h00;
  logic       REQ0_READY;
  logic       REQ1_VALID = 1'b0;
  logic [7:0] REQ1_DATA = 8'h00;
  logic       REQ1_READY;
  logic       TXD;
  logic       BUSY;
  logic       GNT_ID;

  uart_tx_arbiter #(.CLK_DIV(Div)) dut (
    .CLK48MHZ  (CLK48MHZ),
    .RST_N     (RST_N),
    .EN        (EN),
    .REQ0_VALID(REQ0_VALID),
    .REQ0_DATA (REQ0_DATA),
    .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID),
    .REQ1_DATA (REQ1_DATA),
    .REQ1_READY(REQ1_READY),
    .TXD       (TXD),
    .BUSY      (BUSY),
    .GNT_ID    (GNT_ID)
  );

  always #5 CLK48MHZ = ~CLK48MHZ;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a frame is just the list of line levels it will put on TXD, one per cycle.
  logic q[$];
  logic m_busy = 1'b0;
  logic m_txd  = 1'b1;
  logic m_gnt  = 1'b1;

  function automatic logic m_winner();
    if (REQ0_VALID && REQ1_VALID) return !m_gnt;
    return REQ1_VALID;
  endfunction

  function automatic logic m_ready(input logic id);
    logic w;
    w = m_winner();
    return RST_N && EN && !m_busy && (id ? REQ1_VALID : REQ0_VALID) && (w == id);
  endfunction

  initial begin
    forever begin
      @(posedge CLK48MHZ or negedge RST_N);
      if (!RST_N) begin
        q.delete();
        m_busy = 1'b0;
        m_txd  = 1'b1;
        m_gnt  = 1'b1;
      end else begin
        if (m_ready(1'b0) || m_ready(1'b1)) begin
          logic       w;
          logic [7:0] b;
          w = m_winner();
          b = w ? REQ1_DATA : REQ0_DATA;
          m_gnt = w;
          for (int c = 0; c < int'(Div); c++) q.push_back(1'b0);
          for (int i = 0; i < 8; i++)
            for (int c = 0; c < int'(Div); c++) q.push_back(b[i]);
          for (int c = 0; c < int'(Div); c++) q.push_back(1'b1);
        end
        if (q.size() > 0) begin
          m_txd  = q.pop_front();
          m_busy = 1'b1;
        end else begin
          m_txd  = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  end

  always @(negedge CLK48MHZ) begin
    chk("txd", TXD, m_txd);
    chk("busy", BUSY, m_busy);
    chk("gnt_id", GNT_ID, m_gnt);
    chk("ready0", REQ0_READY, m_ready(1'b0));
    chk("ready1", REQ1_READY, m_ready(1'b1));
    chk("ready_onehot", REQ0_READY & REQ1_READY, 1'b0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(posedge CLK48MHZ);
    #1 RST_N = 1'b0;
    #1;
    chk("rst_txd", TXD, 1'b1);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_gnt", GNT_ID, 1'b1);
    chk("rst_ready", {REQ0_READY, REQ1_READY}, 2'b00);
    repeat (3) @(posedge CLK48MHZ);
    @(negedge CLK48MHZ);
    #1 RST_N = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && BUSY; i++) @(negedge CLK48MHZ);
    chk("wait_idle", BUSY, 1'b0);
  endtask

  initial begin
    logic [9:0] a5_bits;
    logic [3:0] rr_exp;
    int         busy_cnt;
    int         got;
    logic       ids[4];

    a5_bits = 10'b1101001010;  // bit b = TXD level of frame bit b (start first)
    rr_exp  = 4'b1010;         // rr_exp[k] = expected id of k-th grant: 0,1,0,1

    // Directed: single requester, 0xA5, data scrambled after acceptance.
    do_reset();
    @(posedge CLK48MHZ);
    #1 EN = 1'b1; REQ0_VALID = 1'b1; REQ0_DATA = 8'hA5;
    @(negedge CLK48MHZ);
    chk("a5_ready", REQ0_READY, 1'b1);
    @(posedge CLK48MHZ);
    #1 REQ0_VALID = 1'b0;
    busy_cnt = 0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < int'(Div); c++) begin
        @(negedge CLK48MHZ);
        REQ0_DATA = 8'($urandom);
        if (BUSY) busy_cnt++;
        if (c == 1) chk("a5_bit", TXD, a5_bits[b]);
      end
    end
    @(negedge CLK48MHZ);
    chk("a5_busy_len", busy_cnt, 40);
    chk("a5_busy_end", BUSY, 1'b0);
    chk("a5_gnt", GNT_ID, 1'b0);

    // Directed: both requesters held, round robin starting with requester 0.
    do_reset();
    @(posedge CLK48MHZ);
    #1 REQ0_VALID = 1'b1; REQ0_DATA = 8'h11; REQ1_VALID = 1'b1; REQ1_DATA = 8'h22;
    got = 0;
    for (int i = 0; i < 400 && got < 4; i++) begin
      @(negedge CLK48MHZ);
      if (REQ0_READY || REQ1_READY) begin
        ids[got] = REQ1_READY;
        got++;
      end
    end
    chk("rr_count", got, 4);
    for (int k = 0; k < 4; k++) chk("rr_order", ids[k], rr_exp[k]);
    @(posedge CLK48MHZ);
    #1 REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    wait_idle();

    // Directed: EN low holds off a waiting requester; grant comes the cycle EN rises.
    @(posedge CLK48MHZ);
    #1 EN = 1'b0; REQ1_VALID = 1'b1; REQ1_DATA = 8'h3C;
    repeat (5) @(negedge CLK48MHZ);
    chk("en0_ready1", REQ1_READY, 1'b0);
    chk("en0_txd", TXD, 1'b1);
    @(posedge CLK48MHZ);
    #1 EN = 1'b1;
    @(negedge CLK48MHZ);
    chk("en1_ready1", REQ1_READY, 1'b1);
    @(posedge CLK48MHZ);
    #1 REQ1_VALID = 1'b0;
    @(negedge CLK48MHZ);
    chk("en1_start_txd", TXD, 1'b0);
    chk("en1_start_busy", BUSY, 1'b1);

    // Directed: EN dropped in data bit 3; frame completes, no grants afterwards.
    repeat (4 * Div + 1) @(negedge CLK48MHZ);
    #1 EN = 1'b0; REQ0_VALID = 1'b1; REQ1_VALID = 1'b1; REQ0_DATA = 8'h5A; REQ1_DATA = 8'hC3;
    repeat (80) @(negedge CLK48MHZ);
    chk("en_drop_busy", BUSY, 1'b0);
    chk("en_drop_ready", {REQ0_READY, REQ1_READY}, 2'b00);
    chk("en_drop_txd", TXD, 1'b1);

    // Directed: reset in data bit 4 aborts; requester 0 wins the first contention after.
    @(posedge CLK48MHZ);
    #1 EN = 1'b1;
    for (int i = 0; i < 10 && !BUSY; i++) @(negedge CLK48MHZ);
    chk("rst_mid_started", BUSY, 1'b1);
    repeat (5 * Div + 1) @(negedge CLK48MHZ);
    #1 RST_N = 1'b0;
    #1;
    chk("rst_mid_txd", TXD, 1'b1);
    chk("rst_mid_busy", BUSY, 1'b0);
    @(negedge CLK48MHZ);
    #1 RST_N = 1'b1;
    #1;
    chk("rst_rel_ready", {REQ0_READY, REQ1_READY}, 2'b10);
    @(negedge CLK48MHZ);
    chk("rst_rel_gnt", GNT_ID, 1'b0);
    @(posedge CLK48MHZ);
    #1 REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;

    // Random traffic, data changing every cycle, occasional EN gaps.
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK48MHZ);
      #1;
      REQ0_VALID = ($urandom_range(0, 9) < 6);
      REQ1_VALID = ($urandom_range(0, 9) < 6);
      REQ0_DATA  = 8'($urandom);
      REQ1_DATA  = 8'($urandom);
      EN         = ($urandom_range(0, 15) != 0);
    end
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    wait_idle();
    @(negedge CLK48MHZ);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
